// File: rtl/div_operand_feeder.sv
// Operand feeder/result collector wrapped around a restoring divider: buffers operand pairs,
// screens divide-by-zero and quotient overflow, launches the divider and returns results.
module div_operand_feeder #(
   parameter int unsigned DEPTH   = 2,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [11:0] in_A,
   input  logic [5:0]  in_Q,
   output logic        div_start,
   output logic [11:0] div_A,
   output logic [5:0]  div_Q,
   input  logic [5:0]  div_Quotient,
   input  logic [5:0]  div_Rem,
   input  logic        div_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [5:0]  out_quotient,
   output logic [5:0]  out_rem,
   output logic [2:0]  out_err,
   output logic        busy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

   state_e          r_state, w_state_nxt;
   logic [11:0]     r_mem_a [DEPTH];
   logic [5:0]      r_mem_q [DEPTH];
   logic [AW-1:0]   r_wptr, r_rptr;
   logic [AW:0]     r_count;
   logic [11:0]     r_div_a, w_div_a_nxt;
   logic [5:0]      r_div_q, w_div_q_nxt;
   logic [CW-1:0]   r_tmo, w_tmo_nxt;
   logic            r_done_prev;
   logic [5:0]      r_out_q, w_out_q_nxt;
   logic [5:0]      r_out_r, w_out_r_nxt;
   logic [2:0]      r_out_err, w_out_err_nxt;

   logic        w_push, w_pop, w_empty, w_full;
   logic [11:0] w_head_a;
   logic [5:0]  w_head_q;
   logic        w_dz, w_ov, w_done_edge;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == (AW+1)'(DEPTH));
   assign w_push      = in_valid && !w_full;
   assign w_head_a    = r_mem_a[r_rptr];
   assign w_head_q    = r_mem_q[r_rptr];
   assign w_dz        = (w_head_q == 6'd0);
   // Quotient fits in 6 bits only when the upper dividend half is below the divisor.
   assign w_ov        = !w_dz && (w_head_a[11:6] >= w_head_q);
   assign w_done_edge = div_done && !r_done_prev;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_a[r_wptr] <= in_A;
         r_mem_q[r_wptr] <= in_Q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_state     <= StIdle;
         r_div_a     <= '0;
         r_div_q     <= '0;
         r_tmo       <= '0;
         r_done_prev <= 1'b0;
         r_out_q     <= '0;
         r_out_r     <= '0;
         r_out_err   <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         r_state     <= w_state_nxt;
         r_div_a     <= w_div_a_nxt;
         r_div_q     <= w_div_q_nxt;
         r_tmo       <= w_tmo_nxt;
         r_done_prev <= div_done;
         r_out_q     <= w_out_q_nxt;
         r_out_r     <= w_out_r_nxt;
         r_out_err   <= w_out_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_div_a_nxt   = r_div_a;
      w_div_q_nxt   = r_div_q;
      w_tmo_nxt     = r_tmo;
      w_out_q_nxt   = r_out_q;
      w_out_r_nxt   = r_out_r;
      w_out_err_nxt = r_out_err;
      unique case (r_state)
         StIdle: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_dz || w_ov) begin
                  w_out_err_nxt = {1'b0, w_ov, w_dz};
                  w_out_q_nxt   = '0;
                  w_out_r_nxt   = '0;
                  w_state_nxt   = StResp;
               end else begin
                  w_div_a_nxt = w_head_a;
                  w_div_q_nxt = w_head_q;
                  w_state_nxt = StLaunch;
               end
            end
         end
         StLaunch: begin
            w_tmo_nxt   = '0;
            w_state_nxt = StWait;
         end
         StWait: begin
            if (w_done_edge) begin
               w_out_q_nxt   = div_Quotient;
               w_out_r_nxt   = div_Rem;
               w_out_err_nxt = 3'b000;
               w_state_nxt   = StResp;
            end else if (r_tmo == CW'(TIMEOUT - 1)) begin
               w_out_q_nxt   = '0;
               w_out_r_nxt   = '0;
               w_out_err_nxt = 3'b100;
               w_state_nxt   = StResp;
            end else begin
               w_tmo_nxt = r_tmo + 1'b1;
            end
         end
         StResp: begin
            if (out_ready) w_state_nxt = StIdle;
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   assign in_ready     = !w_full;
   assign div_start    = (r_state == StLaunch);
   assign div_A        = r_div_a;
   assign div_Q        = r_div_q;
   assign out_valid    = (r_state == StResp);
   assign out_quotient = r_out_q;
   assign out_rem      = r_out_r;
   assign out_err      = r_out_err;
   assign busy         = (r_state != StIdle) || !w_empty;

endmodule

// File: doc/div_operand_feeder.md
Name: div_operand_feeder

Overview:
- Sits directly upstream of Restoring_Divider and also captures its result, so the rest of the design never drives `start` or watches `done` directly.
- Accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a small FIFO.
- Screens each pair for divide-by-zero and quotient overflow, launches the divider with a one-cycle start pulse and waits for completion with a timeout.
- Presents quotient, remainder and error flags over a valid/ready output handshake.

Parameters:
DEPTH, 2, input FIFO entries (power of two, >=2)
TIMEOUT, 1024, clk cycles allowed in WAIT before a timeout error is flagged

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_A  in  12  dividend
in_Q  in  6  divisor
div_start  out  1  one-cycle start pulse to divider
div_A  out  12  dividend to divider, held stable from LAUNCH until leaving WAIT
div_Q  out  6  divisor to divider, held stable likewise
div_Quotient  in  6  divider quotient
div_Rem  in  6  divider remainder
div_done  in  1  divider done
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_quotient  out  6  captured quotient (0 on error)
out_rem  out  6  captured remainder (0 on error)
out_err  out  3  bit0 divide-by-zero, bit1 overflow, bit2 timeout
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst=1), cleared immediately:
  - FIFO empty; state IDLE.
  - div_start=0, div_A=0, div_Q=0.
  - out_valid=0, out_quotient=0, out_rem=0, out_err=0.
  - busy=0; timeout counter=0; done-edge register=0.
  - in_ready=1 after reset releases.
- FIFO:
  - Push when in_valid&&in_ready.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - in_ready=0 when full; in_valid while full is ignored and nothing is overwritten.
  - Pointers wrap modulo DEPTH.
- Operand check (combinational on FIFO head, evaluated at pop):
  - dz = (Q==0).
  - ov = !dz && (A[11:6] >= Q), i.e. quotient would exceed 6 bits.
- FSM:
  - IDLE: if FIFO non-empty, pop.
    - dz or ov: load out_err={0,ov,dz}, out_quotient=0, out_rem=0, go RESP. The divider is never started.
    - Otherwise: latch div_A/div_Q, go LAUNCH.
  - LAUNCH: div_start=1 for exactly this one cycle; clear timeout counter; go WAIT.
  - WAIT:
    - Detect a rising edge of div_done (registered previous value). A done level left high from a prior operation is not accepted.
    - On the edge: capture div_Quotient/div_Rem, out_err=0, go RESP.
    - If the counter reaches TIMEOUT-1 with no edge: out_err=3'b100, outputs 0, go RESP.
  - RESP: out_valid=1; outputs held stable until out_ready.
    - On out_valid&&out_ready: out_valid=0 next cycle, go IDLE.
    - out_ready held high gives one result every cycle-pair minimum (RESP->IDLE->LAUNCH...).
- Latency, valid pair on an empty feeder, from the push edge:
  - head visible next cycle → IDLE pop
  - +1 LAUNCH
  - +1 WAIT
  - divider time
  - +1 after done edge → out_valid.
- Error pair: out_valid 1 cycle after pop.
- Results leave in FIFO order; no reordering.
- rst asserted mid-operation (any state) returns everything to reset values, and buffered pairs are discarded. div_start is never asserted while rst=1.

Test Plan:
1. Reset, push A=12'b001101011000 (856), Q=6'b011101 (29) → exactly one div_start pulse, div_A/div_Q held; after done edge out_valid=1, out_quotient=29, out_rem=15, out_err=0.
2. Back-to-back push of (345,12) and (819,13) with out_ready=1 → two results in order: (28,9) then (63,0); in_ready drops after the second push if the first is still in flight with DEPTH=2 full.
3. Push A=856, Q=0 → no div_start; out_valid with out_err=3'b001, quotient=rem=0. Push A=12'b111111000000, Q=6'b000011 → out_err=3'b010, no div_start.
4. Stub divider holding div_done=1 constantly from before start → no capture; after TIMEOUT cycles out_err=3'b100, out_valid=1.
5. out_ready held low 50 cycles in RESP → outputs stable, out_valid stays 1, no new div_start; raising out_ready → next queued pair launches.
6. Assert rst during WAIT with one pair queued → out_valid=0, busy=0, FIFO empty immediately; no further div_start after rst release.
